comp_serial_sched: RTL

Round-robin scheduler that shares one bit-serial magnitude comparator core between two requesters. Each requester hands over a pair of parallel WIDTH-bit unsigned operands through a valid/ready handshake. The block serializes the pair MSB-first into the core and stops early once the bits differ. It returns greater/equal/less flags tagged with the requester ID through a valid/ready result port. It sits between the parallel operand sources and the serial comparator datapath.

---
 rtl/comp_sched_pkg.sv | 16 +
 rtl/comp_serial_sched_if.sv | 33 +++
 rtl/comp_serial_sched_core.sv | 36 +++
 rtl/comp_serial_sched.sv | 101 ++++++++++
 4 files changed

// File: rtl/comp_sched_pkg.sv
// Shared encodings and reset constants for the serial comparator scheduler.
package comp_sched_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic FLAG_G_RST = 1'b0;
  localparam logic FLAG_E_RST = 1'b1;
  localparam logic FLAG_L_RST = 1'b0;

endpackage

// File: rtl/comp_serial_sched_if.sv
// Requester and result handshakes of the serial comparator scheduler.
interface comp_serial_sched_if
  import comp_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic             res_g;
  logic             res_e;
  logic             res_l;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    input  req0_ready, req1_ready, res_valid, res_id, res_g, res_e, res_l
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
    output req0_ready, req1_ready, res_valid, res_id, res_g, res_e, res_l
  );

endinterface

// File: rtl/comp_serial_sched_core.sv
// Bit-serial MSB-first magnitude comparator; flags freeze at the first differing bit.
module comp_serial_core
  import comp_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic gout,
  output logic eout,
  output logic lout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gout <= FLAG_G_RST;
      eout <= FLAG_E_RST;
      lout <= FLAG_L_RST;
    end else if (clear) begin
      gout <= FLAG_G_RST;
      eout <= FLAG_E_RST;
      lout <= FLAG_L_RST;
    end else if (en && eout) begin
      if (a_bit && !b_bit) begin
        gout <= 1'b1;
        eout <= 1'b0;
      end else if (!a_bit && b_bit) begin
        lout <= 1'b1;
        eout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/comp_serial_sched.sv
// Round-robin scheduler sharing one serial comparator core between two requesters.
// state | meaning
// IDLE  | arbitrate and accept one operand pair
// SHIFT | feed one bit pair per cycle, MSB first
// DONE  | hold result until consumed
module comp_serial_sched
  import comp_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic clk,
  input logic reset,
  comp_serial_sched_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             id_q, last_id_q;
  logic             grant, load, dec, core_clear, core_en;
  logic             bit_a, bit_b, last_bit;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_id_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid && grant;
  assign load           = bus.req0_ready || bus.req1_ready;

  assign bit_a    = a_q[idx_q];
  assign bit_b    = b_q[idx_q];
  assign last_bit = (bit_a != bit_b) || (idx_q == '0);

  always_comb begin
    state_d    = state_q;
    core_clear = 1'b0;
    core_en    = 1'b0;
    dec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = SHIFT;
          core_clear = 1'b1;
        end
      end
      SHIFT: begin
        core_en = 1'b1;
        if (last_bit) state_d = DONE;
        else          dec     = 1'b1;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= grant ? bus.req1_a : bus.req0_a;
        b_q   <= grant ? bus.req1_b : bus.req0_b;
        id_q  <= grant;
        idx_q <= IDX_W'(WIDTH - 1);
      end else if (dec) begin
        idx_q <= idx_q - IDX_W'(1);
      end
      if ((state_q == DONE) && bus.res_ready) last_id_q <= id_q;
    end
  end

  comp_serial_core u_core (
    .clk   (clk),
    .reset (reset),
    .clear (core_clear),
    .en    (core_en),
    .a_bit (bit_a),
    .b_bit (bit_b),
    .gout  (bus.res_g),
    .eout  (bus.res_e),
    .lout  (bus.res_l)
  );

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_id    = id_q;

endmodule
